alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, decode stage offers an operation.
REQ-004 SHALL have port in_ready, output, 1, stage can accept an operation this cycle.
REQ-005 SHALL have port alu_op, input, 2, main-control ALUOp code.
REQ-006 SHALL have port funct, input, 6, R-type funct field.
REQ-007 SHALL have port opa and port opb, input, 32 each, operands A and B.
REQ-008 SHALL have port flush, input, 1, synchronous squash of all held operations.
REQ-009 SHALL have port out_valid, output, 1, EX-side operation present.
REQ-010 SHALL have port out_ready, input, 1, ALU consumes the operation this cycle.
REQ-011 SHALL have port out_ctl, output, 3, ALU control code.
REQ-012 SHALL have port out_a and port out_b, output, 32 each, registered operands.
REQ-013 SHALL have port out_illegal, output, 1, the presented operation had an undecodable code.
REQ-014 SHALL have port illegal_sticky, output, 1, an illegal operation was accepted since reset.
REQ-015 SHALL have port issue_count, output, 16, count of operations consumed.

Function
REQ-016 SHALL decode ctl at acceptance as follows: alu_op 00 gives 010 (ADD); alu_op 01 gives 110 (SUB).
REQ-017 SHALL decode alu_op 10 by funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111.
REQ-018 SHALL treat alu_op 11, or alu_op 10 with any other funct, as illegal: ctl 010 and illegal bit 1.
REQ-019 SHALL hold up to two entries (output register plus skid register), each holding ctl, a, b and illegal.
REQ-020 SHALL drive in_ready as NOT skid_full, from a register only, with no combinational path from out_ready.
REQ-021 SHALL accept an operation when in_valid and in_ready are both 1; SHALL consume an operation when out_valid and out_ready are both 1.
REQ-022 SHALL, on accept with the output register empty or being consumed and the skid register empty, load the output register.
REQ-023 SHALL, on accept while the output register is held (out_valid=1, out_ready=0), load the skid register.
REQ-024 SHALL, on consume with the skid register full, move the skid entry to the output register and clear skid_full, then raise in_ready the next cycle.
REQ-025 SHALL deliver operations in strict accept order; latency from accept to out_valid is 1 cycle when no entry is stalled.
REQ-026 SHALL keep out_ctl, out_a, out_b and out_illegal stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on flush, clear both entries next edge (out_valid=0, in_ready=1); flush has priority over simultaneous accept and consume.
REQ-028 SHALL not advance issue_count on a flushed cycle, and a flushed entry SHALL NOT be counted as consumed.
REQ-029 SHALL increment issue_count by 1 per consume, wrapping from 0xFFFF to 0x0000.
REQ-030 SHALL set illegal_sticky when an illegal operation is accepted; only reset SHALL clear it, and flush SHALL NOT clear it.

Reset
REQ-031 SHALL, while rst=1, force out_valid=0, in_ready=1, skid empty, out_ctl=000, out_a=0, out_b=0, out_illegal=0, illegal_sticky=0 and issue_count=0, asynchronously.
REQ-032 SHALL discard all held operations on reset mid-operation; the first edge after rst deasserts behaves as from empty.

Verification
REQ-033 SHALL pass this scenario: alu_op=10, funct=101010, opa=5, opb=9, out_ready=1 gives, the next cycle, out_valid=1, out_ctl=111, out_a=5, out_b=9, then issue_count=1.
REQ-034 SHALL pass this scenario: out_ready=0 with three back-to-back offers (ADD, SUB, OR) gives the first two accepted, in_ready=0 on the third, and out_ready=1 then yields the order 010, 110, 001.
REQ-035 SHALL pass this scenario: alu_op=11 accepted gives out_illegal=1 and out_ctl=010; illegal_sticky stays 1 after a flush and clears only on rst.
REQ-036 SHALL pass this scenario: flush with both entries full, in_valid=1 and out_ready=1 gives, the next cycle, out_valid=0, in_ready=1, and an unchanged issue_count.
REQ-037 SHALL pass this scenario: issue_count preloaded by 65535 consumes plus one more gives 0x0000.
REQ-038 SHALL pass this scenario: rst asserted mid-cycle with skid full gives out_valid=0 and in_ready=1 immediately, before any clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct into an ALU control code and holds up to
// two operations (output register plus skid register) between decode and EX.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_ctl,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_illegal,
  output logic        illegal_sticky,
  output logic [15:0] issue_count
);

  typedef enum logic [2:0] {
    CTL_AND = 3'b000,
    CTL_OR  = 3'b001,
    CTL_ADD = 3'b010,
    CTL_SUB = 3'b110,
    CTL_SLT = 3'b111
  } ctl_e;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } entry_t;

  entry_t      out_q, out_d, skid_q, skid_d, new_entry;
  logic        out_valid_q, out_valid_d;
  logic        skid_full_q, skid_full_d;
  logic        sticky_q, sticky_d;
  logic [15:0] cnt_q, cnt_d;
  ctl_e        dec_ctl;
  logic        dec_ill;
  logic        accept, consume;

  always_comb begin
    dec_ctl = CTL_ADD;
    dec_ill = 1'b0;
    unique case (alu_op)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        unique case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign new_entry = '{ctl: dec_ctl, a: opa, b: opb, ill: dec_ill};
  assign accept    = in_valid & ~skid_full_q;
  assign consume   = out_valid_q & out_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else begin
      if (consume) cnt_d = cnt_q + 16'd1;
      if (accept && dec_ill) sticky_d = 1'b1;
      // A full skid implies in_ready=0, so skid drain and accept never coincide.
      if (consume && skid_full_q) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end else if (accept && (!out_valid_q || consume)) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else if (accept) begin
        skid_d      = new_entry;
        skid_full_d = 1'b1;
      end else if (consume) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready       = ~skid_full_q;
  assign out_valid      = out_valid_q;
  assign out_ctl        = out_q.ctl;
  assign out_a          = out_q.a;
  assign out_b          = out_q.b;
  assign out_illegal    = out_q.ill;
  assign illegal_sticky = sticky_q;
  assign issue_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries are queued at accept
// and compared at consume; queue depth models out_valid/in_ready.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] opa, opb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctl;
  logic [31:0] out_a, out_b;
  logic        out_illegal;
  logic        illegal_sticky;
  logic [15:0] issue_count;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opa(opa), .opb(opb),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctl(out_ctl), .out_a(out_a), .out_b(out_b),
    .out_illegal(out_illegal), .illegal_sticky(illegal_sticky),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_cnt;
  logic        m_sticky;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a; e.b = b; e.ctl = 3'b010; e.ill = 1'b0;
    if (op == 2'b01) e.ctl = 3'b110;
    else if (op == 2'b11) e.ill = 1'b1;
    else if (op == 2'b10) begin
      if      (fn == 6'h20) e.ctl = 3'b010;
      else if (fn == 6'h22) e.ctl = 3'b110;
      else if (fn == 6'h24) e.ctl = 3'b000;
      else if (fn == 6'h25) e.ctl = 3'b001;
      else if (fn == 6'h2A) e.ctl = 3'b111;
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl);
    exp_t e;
    logic cons, acc;
    in_valid = v; alu_op = op; funct = fn; opa = a; opb = b;
    out_ready = ordy; flush = fl;
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    check("issue_count", {48'd0, issue_count}, {48'd0, m_cnt});
    check("illegal_sticky", {63'd0, illegal_sticky}, {63'd0, m_sticky});
    cons = (sb.size() > 0) && ordy;
    acc  = v && (sb.size() < 2);
    if (cons) begin
      e = sb[0];
      check("out_ctl", {61'd0, out_ctl}, {61'd0, e.ctl});
      check("out_a", {32'd0, out_a}, {32'd0, e.a});
      check("out_b", {32'd0, out_b}, {32'd0, e.b});
      check("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
    end
    if (fl) sb.delete();
    else begin
      if (cons) begin
        void'(sb.pop_front());
        m_cnt++;
      end
      if (acc) begin
        e = model(op, fn, a, b);
        sb.push_back(e);
        if (e.ill) m_sticky = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 6'h00, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_ctl", {61'd0, out_ctl}, 64'd0);
    check("rst_out_a", {32'd0, out_a}, 64'd0);
    check("rst_out_b", {32'd0, out_b}, 64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    check("rst_sticky", {63'd0, illegal_sticky}, 64'd0);
    check("rst_count", {48'd0, issue_count}, 64'd0);
    sb.delete();
    m_cnt = '0;
    m_sticky = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] fn_tab [0:5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

  initial begin
    rst = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0;
    opa = '0; opb = '0; flush = 1'b0; out_ready = 1'b0;
    m_cnt = '0; m_sticky = 1'b0;
    do_reset();

    // SLT scenario
    step(1'b1, 2'b10, 6'h2A, 32'd5, 32'd9, 1'b1, 1'b0);
    check("slt_ctl", {61'd0, out_ctl}, 64'd7);
    idle(1'b1);
    check("slt_count", {48'd0, issue_count}, 64'd1);

    // Back-to-back under stall: third offer refused
    step(1'b1, 2'b00, 6'h00, 32'd1, 32'd2, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'h00, 32'd3, 32'd4, 1'b0, 1'b0);
    step(1'b1, 2'b10, 6'h25, 32'd5, 32'd6, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 2'b10, 6'h25, 32'd5, 32'd6, 1'b1, 1'b0);
    idle(1'b1);

    // Illegal op, sticky survives flush, clears on reset
    step(1'b1, 2'b11, 6'h20, 32'hAA, 32'hBB, 1'b0, 1'b0);
    step(1'b1, 2'b10, 6'h3F, 32'hCC, 32'hDD, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b0, 2'b00, 6'h00, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(1'b0);
    check("sticky_after_flush", {63'd0, illegal_sticky}, 64'd1);

    // Flush with both entries full, simultaneous offer and consume
    step(1'b1, 2'b00, 6'h00, 32'd7, 32'd8, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'h00, 32'd9, 32'd10, 1'b0, 1'b0);
    step(1'b1, 2'b00, 6'h00, 32'd11, 32'd12, 1'b1, 1'b1);
    idle(1'b1);

    // Reset mid-operation with skid full
    step(1'b1, 2'b00, 6'h00, 32'd1, 32'd1, 1'b0, 1'b0);
    step(1'b1, 2'b00, 6'h00, 32'd2, 32'd2, 1'b0, 1'b0);
    do_reset();
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           fn_tab[$urandom_range(0, 5)], $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    do_reset();

    // issue_count wrap
    step(1'b1, 2'b00, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 65535; i++)
      step(1'b1, 2'b00, 6'h00, i, ~i, 1'b1, 1'b0);
    check("pre_wrap", {48'd0, issue_count}, 64'hFFFF);
    idle(1'b1);
    check("wrap", {48'd0, issue_count}, 64'd0);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
